// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer: fetches 16-bit instructions, steers an external ALU and
// register file, and resolves jumps/branches from flags captured on ALU write-back.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic        lsb,
  input  logic        neg,
  output logic [7:0]  imem_addr,
  output logic [3:0]  alu_sel,
  output logic [3:0]  a_sel,
  output logic [3:0]  dst_sel,
  output logic        ld_en,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

  state_t      state, next_state;
  logic [7:0]  pc, next_pc;
  logic [3:0]  ir_op, ir_dst, ir_src;
  logic        lsb_f, neg_f;
  logic        halt_now;

  logic [3:0]  opcode;
  logic [3:0]  fld_x;
  logic [7:0]  fld_y;

  assign opcode = instr[15:12];
  assign fld_x  = instr[11:8];
  assign fld_y  = instr[7:0];

  // State and datapath registers; only the fields the ALU path needs are kept from ir.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= 8'h00;
      ir_op  <= 4'h0;
      ir_dst <= 4'h0;
      ir_src <= 4'h0;
      lsb_f  <= 1'b0;
      neg_f  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      done  <= halt_now;
      if (state == DECODE) begin
        ir_op  <= opcode;
        ir_dst <= fld_x;
        ir_src <= fld_y[3:0];
      end
      if (state == WB) begin
        lsb_f <= lsb;
        neg_f <= neg;
      end
    end
  end

  // Next-state and program-counter logic; a start arriving with the done pulse is ignored.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    halt_now   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done) begin
          next_state = FETCH;
          next_pc    = 8'h00;
        end
      end
      FETCH: next_state = DECODE;
      DECODE: begin
        next_state = FETCH;
        if (opcode == 4'd0) begin
          next_pc = pc + 8'd1;
        end else if (opcode <= 4'd13) begin
          next_state = EXEC;
        end else if (opcode == 4'd14) begin
          next_pc = fld_y;
        end else begin
          case (fld_x[1:0])
            2'b00:   next_pc = neg_f  ? fld_y : pc + 8'd1;
            2'b01:   next_pc = lsb_f  ? fld_y : pc + 8'd1;
            2'b10:   next_pc = !neg_f ? fld_y : pc + 8'd1;
            default: begin
              next_state = IDLE;
              halt_now   = 1'b1;
            end
          endcase
        end
      end
      EXEC: next_state = WB;
      WB: begin
        next_state = FETCH;
        next_pc    = pc + 8'd1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand selects stay on ir from EXEC through WB so the register file sees a stable target.
  always_comb begin
    busy      = (state != IDLE);
    imem_addr = pc;
    alu_sel   = 4'h0;
    a_sel     = 4'h0;
    dst_sel   = 4'h0;
    ld_en     = 1'b0;
    if (state == EXEC) begin
      alu_sel = ir_op;
      a_sel   = ir_src;
      dst_sel = ir_dst;
    end else if (state == WB) begin
      a_sel   = ir_src;
      dst_sel = ir_dst;
      ld_en   = 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: an instruction-level model walks the program and
// predicts the control outputs of every cycle each instruction occupies.
module tb_alu_sequencer;

  logic        clk, rst, start, lsb, neg, ld_en, busy, done;
  logic [15:0] instr;
  logic [7:0]  imem_addr;
  logic [3:0]  alu_sel, a_sel, dst_sel;

  logic [15:0] mem [256];
  logic [22:0] obs;
  int          errors = 0;
  int          checks = 0;

  // Model state: architectural pc and the flags from the last completed ALU op.
  logic [7:0]  pc_m;
  logic        lsb_m, neg_m;
  logic        halted;
  int          ovr_neg;

  localparam logic [22:0] M_CTL = 23'h7F00FF;
  localparam logic [22:0] M_ALL = 23'h7FFFFF;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .lsb(lsb), .neg(neg),
    .imem_addr(imem_addr), .alu_sel(alu_sel), .a_sel(a_sel), .dst_sel(dst_sel),
    .ld_en(ld_en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) instr <= mem[imem_addr];

  assign obs = {busy, done, ld_en, alu_sel, a_sel, dst_sel, imem_addr};

  function automatic logic [22:0] mk(input logic b, input logic d, input logic l,
                                     input logic [3:0] alu, input logic [3:0] a,
                                     input logic [3:0] dst, input logic [7:0] addr);
    return {b, d, l, alu, a, dst, addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    lsb = 1'($urandom);
    neg = 1'($urandom);
  endtask

  task automatic model_reset();
    pc_m  = 8'h00;
    lsb_m = 1'b0;
    neg_m = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    pc_m  = 8'h00;
  endtask

  // Executes one instruction from the FETCH cycle onward, checking every cycle it spans.
  task automatic run_instr(input string tag);
    logic [15:0] w;
    logic [3:0]  op, x;
    logic [7:0]  y;
    logic        taken;
    logic [22:0] e;
    w  = mem[pc_m];
    op = w[15:12];
    x  = w[11:8];
    y  = w[7:0];
    halted = 1'b0;
    e = mk(1, 0, 0, 4'h0, 4'h0, 4'h0, pc_m);
    checks++;
    if ((obs & M_CTL) !== e) begin
      errors++;
      $display("[TB] FAIL %s fetch: got %h want %h", tag, obs & M_CTL, e);
    end
    tick();
    checks++;
    if ((obs & M_CTL) !== e) begin
      errors++;
      $display("[TB] FAIL %s decode: got %h want %h", tag, obs & M_CTL, e);
    end
    tick();
    if (op >= 4'd1 && op <= 4'd13) begin
      e = mk(1, 0, 0, op, w[3:0], x, pc_m);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s exec: got %h want %h", tag, obs, e);
      end
      tick();
      if (ovr_neg >= 0) neg = ovr_neg[0];
      lsb_m = lsb;
      neg_m = neg;
      e = mk(1, 0, 1, 4'h0, w[3:0], x, pc_m);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL %s wb: got %h want %h", tag, obs, e);
      end
      tick();
      pc_m = pc_m + 8'd1;
    end else if (op == 4'd0) begin
      pc_m = pc_m + 8'd1;
    end else if (op == 4'd14) begin
      pc_m = y;
    end else if (x[1:0] == 2'b11) begin
      halted = 1'b1;
      e = mk(0, 1, 0, 4'h0, 4'h0, 4'h0, pc_m);
      checks++;
      if ((obs & M_CTL) !== e) begin
        errors++;
        $display("[TB] FAIL %s halt: got %h want %h", tag, obs & M_CTL, e);
      end
    end else begin
      case (x[1:0])
        2'b00:   taken = neg_m;
        2'b01:   taken = lsb_m;
        default: taken = !neg_m;
      endcase
      pc_m = taken ? y : pc_m + 8'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    model_reset();
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h want %h", obs, 23'h0);
    end
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("[TB] FAIL idle_wait: got %h want %h", obs, 23'h0);
    end
  endtask

  task automatic test_alu();
    mem[0] = 16'h9302;
    mem[1] = 16'hF300;
    do_start();
    run_instr("alu_add");
    run_instr("alu_halt");
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_width: got %b want 0", done);
    end
  endtask

  task automatic test_branch();
    mem[8'h00] = 16'h1100;
    mem[8'h01] = 16'hF040;
    mem[8'h40] = 16'h1100;
    mem[8'h41] = 16'hF050;
    mem[8'h42] = 16'hF300;
    do_start();
    ovr_neg = 1;
    run_instr("brn_setneg");
    run_instr("brn_taken");
    checks++;
    if (imem_addr !== 8'h40) begin
      errors++;
      $display("[TB] FAIL brn_target: got %h want %h", imem_addr, 8'h40);
    end
    ovr_neg = 0;
    run_instr("brn_clrneg");
    run_instr("brn_untaken");
    ovr_neg = -1;
    checks++;
    if (imem_addr !== 8'h42) begin
      errors++;
      $display("[TB] FAIL brn_fallthru: got %h want %h", imem_addr, 8'h42);
    end
    run_instr("brn_halt");
    tick();
  endtask

  task automatic test_wrap();
    mem[8'h00] = 16'hE0FF;
    mem[8'hFF] = 16'h0000;
    do_start();
    run_instr("wrap_jmp");
    run_instr("wrap_nop");
    mem[8'h00] = 16'hF300;
    run_instr("wrap_fetch0");
    tick();
  endtask

  task automatic test_halt_start();
    mem[0] = 16'h0000;
    mem[1] = 16'h2501;
    mem[2] = 16'hF300;
    start = 1'b1;
    tick();
    pc_m = 8'h00;
    run_instr("busy_nop");
    run_instr("busy_alu");
    run_instr("busy_halt");
    tick();
    start = 1'b0;
    checks++;
    if ((obs & M_CTL) !== mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 8'h02)) begin
      errors++;
      $display("[TB] FAIL start_on_done: got %h want %h", obs & M_CTL,
               mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 8'h02));
    end
  endtask

  task automatic test_mid_reset();
    mem[0] = 16'h9302;
    do_start();
    tick();
    tick();
    checks++;
    if (alu_sel !== 4'd9) begin
      errors++;
      $display("[TB] FAIL midrst_exec: got %h want %h", alu_sel, 4'd9);
    end
    rst = 1'b1;
    tick();
    model_reset();
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got %h want %h", obs, 23'h0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("[TB] FAIL midrst_noload: got %h want %h", obs, 23'h0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_start();
    for (int n = 0; n < 120; n++) begin
      run_instr("random");
      if (halted) begin
        tick();
        do_start();
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    lsb     = 1'b0;
    neg     = 1'b0;
    ovr_neg = -1;
    halted  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    model_reset();
    test_reset();
    test_alu();
    test_branch();
    test_wrap();
    test_halt_start();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
